// File: rtl/instr_deserializer_pkg.sv
// rtl/instr_deserializer_pkg.sv - shared control package for the instruction deserializer
//
// Holds the FSM state encoding, default frame geometry and the generic
// clog2 helper used to size counters in the deserializer.
package instr_deserializer_pkg;

  localparam int ADDRW_DEF   = 24;
  localparam int OPCODEW_DEF = 2;

  // Bytes per address field and per complete frame at default geometry.
  localparam int FIELD_BYTES = ADDRW_DEF / 8;
  localparam int NB          = 1 + 3 * FIELD_BYTES;

  // Width of one assembled instruction as stored by the downstream queues.
  localparam int INSTRW      = OPCODEW_DEF + 3 * ADDRW_DEF;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_KEY  = 3'd1,
    ST_TEXT = 3'd2,
    ST_DEST = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

  function automatic int field_bytes(input int addrw);
    return addrw / 8;
  endfunction

  function automatic int frame_bytes(input int addrw);
    return 1 + 3 * (addrw / 8);
  endfunction

endpackage

// File: rtl/instr_deserializer.sv
// rtl/instr_deserializer.sv - byte-stream to instruction deserializer with idle timeout
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/in_valid      byte stream from the CPU link
//   in_ready              byte taken on in_valid && in_ready
//   ready_in_aes/sha      downstream queue readiness, picked by opcode[0]
//   opcode, key_addr,
//   text_addr, dest_addr  assembled instruction, meaningful while valid_out
//   valid_out             instruction held for the downstream queue
//   frame_err             one-cycle pulse when a partial frame times out
module instr_deserializer
  import instr_deserializer_pkg::*;
#(
  parameter int ADDRW   = 24,
  parameter int OPCODEW = 2,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               ready_in_aes,
  input  logic               ready_in_sha,
  output logic [OPCODEW-1:0] opcode,
  output logic [ADDRW-1:0]   key_addr,
  output logic [ADDRW-1:0]   text_addr,
  output logic [ADDRW-1:0]   dest_addr,
  output logic               valid_out,
  output logic               frame_err
);

  localparam int FB    = field_bytes(ADDRW);
  localparam int BCW   = (clog2(FB) < 1) ? 1 : clog2(FB);
  localparam int IDLEW = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);

  state_t             state;
  state_t             state_nx;
  logic [BCW-1:0]     byte_cnt;
  logic [IDLEW-1:0]   idle_cnt;

  // Assembly registers: the visible outputs only change when a frame
  // completes, so a frame in progress or one that is later dropped never
  // disturbs the last delivered instruction.
  logic [OPCODEW-1:0] asm_opcode;
  logic [ADDRW-1:0]   asm_key;
  logic [ADDRW-1:0]   asm_text;
  logic [ADDRW-1:0]   asm_dest;

  logic accept;
  logic in_field;
  logic last_byte;
  logic sel_ready;
  logic timeout;

  assign in_ready  = (state != ST_HOLD);
  assign valid_out = (state == ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign in_field  = (state == ST_KEY) || (state == ST_TEXT) || (state == ST_DEST);
  assign last_byte = (byte_cnt == BCW'(FB - 1));
  assign sel_ready = opcode[0] ? ready_in_sha : ready_in_aes;

  // The timeout fires on the edge where the idle count would reach TIMEOUT;
  // a byte accepted on that same edge wins and keeps the frame alive.
  assign timeout = in_field && !accept && ((int'(idle_cnt) + 1) >= TIMEOUT);

  always_comb begin
    state_nx = state;
    case (state)
      ST_HDR: begin
        if (accept) state_nx = ST_KEY;
      end
      ST_KEY: begin
        if (accept && last_byte) state_nx = ST_TEXT;
        else if (timeout)        state_nx = ST_HDR;
      end
      ST_TEXT: begin
        if (accept && last_byte) state_nx = ST_DEST;
        else if (timeout)        state_nx = ST_HDR;
      end
      ST_DEST: begin
        if (accept && last_byte) state_nx = ST_HOLD;
        else if (timeout)        state_nx = ST_HDR;
      end
      ST_HOLD: begin
        if (sel_ready) state_nx = ST_HDR;
      end
      default: state_nx = ST_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HDR;
      byte_cnt  <= '0;
      idle_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      frame_err <= timeout;

      if (state_nx != state) begin
        byte_cnt <= '0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 1'b1;
      end

      if (!in_field || accept || timeout) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_opcode <= '0;
      asm_key    <= '0;
      asm_text   <= '0;
      asm_dest   <= '0;
      opcode     <= '0;
      key_addr   <= '0;
      text_addr  <= '0;
      dest_addr  <= '0;
    end else if (accept) begin
      case (state)
        ST_HDR:  asm_opcode <= in_data[OPCODEW-1:0];
        ST_KEY:  asm_key    <= ADDRW'({asm_key, in_data});
        ST_TEXT: asm_text   <= ADDRW'({asm_text, in_data});
        ST_DEST: begin
          asm_dest <= ADDRW'({asm_dest, in_data});
          if (last_byte) begin
            opcode    <= asm_opcode;
            key_addr  <= asm_key;
            text_addr <= asm_text;
            dest_addr <= ADDRW'({asm_dest, in_data});
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_deserializer.sv
// tb/tb_instr_deserializer.sv - scoreboard bench for instr_deserializer
//
// Drives byte frames (directed and random) into the deserializer; a frame
// model turns each accepted byte sequence into expected instructions and
// expected frame_err pulses, which a negedge monitor pops and compares.
module tb_instr_deserializer;

  localparam int ADDRW   = 24;
  localparam int OPCODEW = 2;
  localparam int TIMEOUT = 255;
  localparam int FB      = ADDRW / 8;
  localparam int NB      = 1 + 3 * FB;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic               ready_in_aes = 1'b1;
  logic               ready_in_sha = 1'b1;
  logic [OPCODEW-1:0] opcode;
  logic [ADDRW-1:0]   key_addr;
  logic [ADDRW-1:0]   text_addr;
  logic [ADDRW-1:0]   dest_addr;
  logic               valid_out;
  logic               frame_err;

  instr_deserializer #(
    .ADDRW(ADDRW),
    .OPCODEW(OPCODEW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .ready_in_aes(ready_in_aes),
    .ready_in_sha(ready_in_sha),
    .opcode(opcode),
    .key_addr(key_addr),
    .text_addr(text_addr),
    .dest_addr(dest_addr),
    .valid_out(valid_out),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OPCODEW-1:0] op;
    logic [ADDRW-1:0]   key;
    logic [ADDRW-1:0]   text;
    logic [ADDRW-1:0]   dest;
  } instr_t;

  instr_t exp_q[$];
  int     rise_q[$];
  int     err_pending = 0;
  int     err_seen    = 0;
  int     n_done      = 0;
  int     last_hold_len = 0;
  int     checks = 0;
  int     errors = 0;
  int     rdy_mode = 0;

  logic [7:0] fbuf [NB];
  int         fpos = 0;
  int         gap_acc = 0;

  function automatic void check(input string nm, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  // Downstream readiness: 0 = both ready, 1 = random, 2 = AES stalled, SHA ready.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      1: begin
        ready_in_aes = ($urandom_range(0, 3) != 0);
        ready_in_sha = ($urandom_range(0, 3) != 0);
      end
      2: begin
        ready_in_aes = 1'b0;
        ready_in_sha = 1'b1;
      end
      default: begin
        ready_in_aes = 1'b1;
        ready_in_sha = 1'b1;
      end
    endcase
  end

  // Frame model: NB bytes make one instruction, fields MSB first.
  task automatic model_byte(input logic [7:0] b);
    instr_t e;
    gap_acc = 0;
    fbuf[fpos] = b;
    fpos++;
    if (fpos == NB) begin
      e.op   = fbuf[0][OPCODEW-1:0];
      e.key  = '0;
      e.text = '0;
      e.dest = '0;
      for (int i = 0; i < FB; i++) begin
        e.key  = (e.key  << 8) | ADDRW'(fbuf[1 + i]);
        e.text = (e.text << 8) | ADDRW'(fbuf[1 + FB + i]);
        e.dest = (e.dest << 8) | ADDRW'(fbuf[1 + 2 * FB + i]);
      end
      exp_q.push_back(e);
      fpos = 0;
    end
  endtask

  task automatic idle(input int n);
    if (fpos > 0 && gap_acc + n >= TIMEOUT) begin
      err_pending++;
      fpos = 0;
    end
    gap_acc += n;
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    int n;
    idle(gap);
    model_byte(b);
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 1000) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: in_ready actual=0 required=1 within 1000 cycles");
    end
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [ADDRW-1:0] k,
                            input logic [ADDRW-1:0] t, input logic [ADDRW-1:0] d,
                            output int hdr_cyc);
    send_byte(hdr, 0);
    hdr_cyc = cyc;
    for (int i = 0; i < FB; i++) send_byte(8'(k >> (8 * (FB - 1 - i))), 0);
    for (int i = 0; i < FB; i++) send_byte(8'(t >> (8 * (FB - 1 - i))), 0);
    for (int i = 0; i < FB; i++) send_byte(8'(d >> (8 * (FB - 1 - i))), 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor
  logic               prev_valid = 1'b0;
  logic               prev_hs    = 1'b0;
  logic               prev_err   = 1'b0;
  logic [OPCODEW-1:0] p_op;
  logic [ADDRW-1:0]   p_key, p_text, p_dest;
  int                 hold_len = 0;

  always @(negedge clk) begin
    logic   hs;
    instr_t e;
    hs = 1'b0;
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      prev_err   = 1'b0;
    end else begin
      check("in_ready_vs_hold", 96'(in_ready), 96'(!valid_out));
      if (prev_hs) check("valid_after_handshake", 96'(valid_out), 96'(0));
      if (valid_out) begin
        if (prev_valid && !prev_hs) begin
          check("hold_opcode", 96'(opcode), 96'(p_op));
          check("hold_key", 96'(key_addr), 96'(p_key));
          check("hold_text", 96'(text_addr), 96'(p_text));
          check("hold_dest", 96'(dest_addr), 96'(p_dest));
        end
        if (!prev_valid || prev_hs) begin
          rise_q.push_back(cyc);
          hold_len = 0;
        end
        hold_len++;
        hs = opcode[0] ? ready_in_sha : ready_in_aes;
        if (hs) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL instr_unexpected: actual op=%0h key=%0h required none", opcode, key_addr);
          end else begin
            e = exp_q.pop_front();
            check("instr_opcode", 96'(opcode), 96'(e.op));
            check("instr_key", 96'(key_addr), 96'(e.key));
            check("instr_text", 96'(text_addr), 96'(e.text));
            check("instr_dest", 96'(dest_addr), 96'(e.dest));
          end
          last_hold_len = hold_len;
          n_done++;
        end
      end
      if (frame_err) begin
        err_seen++;
        check("frame_err_width", 96'(prev_err), 96'(0));
        checks++;
        if (err_pending == 0) begin
          errors++;
          $display("FAIL frame_err_unexpected: actual=1 required=0");
        end else begin
          err_pending--;
        end
      end
      prev_valid = valid_out;
      prev_hs    = hs;
      prev_err   = frame_err;
      p_op   = opcode;
      p_key  = key_addr;
      p_text = text_addr;
      p_dest = dest_addr;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    int e0;
    int d0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 96'(in_ready), 96'(1));
    check("rst_valid_out", 96'(valid_out), 96'(0));
    check("rst_frame_err", 96'(frame_err), 96'(0));
    check("rst_opcode", 96'(opcode), 96'(0));
    check("rst_key", 96'(key_addr), 96'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back frame, SHA opcode: valid NB-1 cycles after header accept.
    rise_q.delete();
    send_frame(8'h01, 24'hAABBCC, 24'h112233, 24'h445566, h);
    wait_idle();
    check("s1_rise_count", 96'(rise_q.size()), 96'(1));
    if (rise_q.size() > 0) check("s1_latency", 96'(rise_q[0] - h), 96'(NB - 1));
    check("s1_hold_len", 96'(last_hold_len), 96'(1));

    // AES opcode stalled 5 cycles while SHA stays ready; upper header bits ignored.
    rdy_mode = 2;
    send_frame(8'hFC, 24'h0A0B0C, 24'hDEAD01, 24'hBEEF02, h);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rdy_mode = 0;
    wait_idle();
    check("s2_hold_len", 96'(last_hold_len), 96'(6));

    // Partial frame abandoned for TIMEOUT cycles, then a full frame.
    e0 = err_seen;
    send_byte(8'h02, 0);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h30 + i), 0);
    idle(TIMEOUT);
    @(negedge clk);
    check("s3_in_ready_after_timeout", 96'(in_ready), 96'(1));
    @(posedge clk);
    #1;
    send_frame(8'h03, 24'h123456, 24'h789ABC, 24'hDEF012, h);
    wait_idle();
    check("s3_err_count", 96'(err_seen - e0), 96'(1));

    // Byte lands on the timeout edge: accepted, no error.
    e0 = err_seen;
    d0 = n_done;
    send_byte(8'h01, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    send_byte(8'h77, TIMEOUT - 1);
    for (int i = 0; i < NB - 4; i++) send_byte(8'(8'hA0 + i), 0);
    wait_idle();
    check("s4_err_count", 96'(err_seen - e0), 96'(0));
    check("s4_done", 96'(n_done - d0), 96'(1));

    // Reset during the 6th byte.
    for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), 0);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    rst_n    = 1'b0;
    fpos     = 0;
    gap_acc  = 0;
    @(negedge clk);
    check("s5_in_ready", 96'(in_ready), 96'(1));
    check("s5_valid_out", 96'(valid_out), 96'(0));
    check("s5_frame_err", 96'(frame_err), 96'(0));
    check("s5_opcode", 96'(opcode), 96'(0));
    check("s5_key", 96'(key_addr), 96'(0));
    check("s5_text", 96'(text_addr), 96'(0));
    check("s5_dest", 96'(dest_addr), 96'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(8'h02, 24'h0F1E2D, 24'h3C4B5A, 24'h697887, h);
    wait_idle();

    // Four frames streamed with ready held high.
    rise_q.delete();
    for (int f = 0; f < 4; f++) begin
      send_frame(8'(f), 24'($urandom), 24'($urandom), 24'($urandom), h);
    end
    wait_idle();
    check("s6_rise_count", 96'(rise_q.size()), 96'(4));
    for (int i = 1; i < rise_q.size(); i++) begin
      check("s6_spacing", 96'(rise_q[i] - rise_q[i - 1]), 96'(NB + 1));
    end

    // Random bytes, gaps and downstream readiness.
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      int r;
      int g;
      r = $urandom_range(0, 19);
      if (r < 14)       g = 0;
      else if (r < 18)  g = $urandom_range(1, 5);
      else if (r == 18) g = TIMEOUT - 1;
      else              g = TIMEOUT + $urandom_range(0, 20);
      send_byte(8'($urandom), g);
    end
    idle(TIMEOUT + 5);
    rdy_mode = 0;
    wait_idle();

    check("end_pending_instr", 96'(exp_q.size()), 96'(0));
    check("end_pending_err", 96'(err_pending), 96'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
